// File: rtl/xor_and_sweep_ctrl.sv
// Self-test sequencer for the 3-input XOR-then-AND gate: sweeps {a,b,c} 0..7, samples y, scores it.
// Optional build macro SWEEP_CONTINUOUS_EN: after DONE the sweep restarts until abort.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held on the outputs
// SETTLE | current vector driven, settle counter running down
// SAMPLE | y_in captured and scored for the current vector
// DONE   | sweep finished; done pulse and pass verdict registered
module xor_and_sweep_ctrl #(
    parameter logic [7:0]  EXP_TT     = 8'h28,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_cnt,
    output logic [7:0] capture
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Reload value makes each vector sit SETTLE_CYC cycles in SETTLE before its SAMPLE cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       abc_q, abc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       fail_q, fail_d;
    logic [7:0]       cap_q, cap_d;

    always_comb begin
        state_d = state_q;
        abc_d   = abc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        cap_d   = cap_q;

        if (abort && (state_q != S_IDLE)) begin
            // Partial capture and fail count are kept for inspection.
            state_d = S_IDLE;
            abc_d   = 3'd0;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_SETTLE;
                        abc_d   = 3'd0;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                        fail_d  = 4'd0;
                        pass_d  = 1'b0;
                        cap_d   = 8'h00;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = S_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    cap_d[abc_q] = y_in;
                    if (y_in != EXP_TT[abc_q]) begin
                        fail_d = fail_q + 4'd1;
                    end
                    if (abc_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETTLE;
                        abc_d   = abc_q + 3'd1;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                    pass_d = (fail_q == 4'd0);
`ifdef SWEEP_CONTINUOUS_EN
                    state_d = S_SETTLE;
                    abc_d   = 3'd0;
                    cnt_d   = CNT_LOAD;
                    fail_d  = 4'd0;
                    cap_d   = 8'h00;
`else
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            abc_q   <= 3'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 4'd0;
            cap_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            abc_q   <= abc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            cap_q   <= cap_d;
        end
    end

    assign a        = abc_q[2];
    assign b        = abc_q[1];
    assign c        = abc_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_cnt = fail_q;
    assign capture  = cap_q;

endmodule

// File: tb/tb_xor_and_sweep_ctrl.sv
// Bench for xor_and_sweep_ctrl: gate models drive y_in, done results checked from a scoreboard queue.
// Build with SWEEP_CONTINUOUS_EN defined to exercise the continuous-sweep variant.
module tb_xor_and_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       y_in;
    logic       a, b, c, busy, done, pass;
    logic [3:0] fail_cnt;
    logic [7:0] capture;

    int mode = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_seen = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] cap;
        logic [3:0] fc;
        logic       ps;
        logic       bsy;
        int         due;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int         mode;
        logic [7:0] cap;
        logic [3:0] fc;
        logic       ps;
    } vec_t;
    vec_t tbl[5];

    xor_and_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .capture(capture)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: 0 good, 1 stuck-at-0, 2 inverted, 3 stuck-at-1, 4 y follows a
    always_comb begin
        y_in = 1'b0;
        case (mode)
            0: y_in = (a ^ b) & c;
            1: y_in = 1'b0;
            2: y_in = ~((a ^ b) & c);
            3: y_in = 1'b1;
            4: y_in = a;
            default: y_in = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            sb_t e;
            done_seen++;
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_latency", cyc, e.due);
                chk("capture", capture, e.cap);
                chk("fail_cnt", fail_cnt, e.fc);
                chk("pass", pass, e.ps);
                chk("busy_at_done", busy, e.bsy);
            end
        end
    end

    function automatic logic [2:0] exp_abc(input int j);
        return (j < 40) ? 3'(j / 5) : 3'd7;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; start_cyc = cyc;
    endtask

    task automatic wait_sb_empty(input int limit);
        int w = 0;
        while (sb.size() != 0 && w < limit) begin
            @(negedge clk); w++;
        end
        chk("done_timeout", sb.size(), 0);
    endtask

    task automatic run_sweep(input vec_t v, input bit poke_done);
        sb_t e;
        int bad = 0;
        mode = v.mode;
        pulse_start();
        e.cap = v.cap; e.fc = v.fc; e.ps = v.ps; e.bsy = 1'b0; e.due = start_cyc + 41;
        sb.push_back(e);
        if ({a, b, c} !== 3'd0 || busy !== 1'b1) bad++;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 40 && poke_done) start = 1'b1;
            if ({a, b, c} !== exp_abc(j)) bad++;
            if (busy !== 1'b1) bad++;
        end
        chk("abc_seq", bad, 0);
        @(negedge clk); start = 1'b0;
        wait_sb_empty(10);
        repeat (3) @(negedge clk);
        if (poke_done) begin
            chk("start_in_done_ignored_busy", busy, 1'b0);
            chk("start_in_done_ignored_abc", {a, b, c}, 3'd7);
        end
        chk("pass_held", pass, v.ps);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int seen0;
        tbl[0] = '{0, 8'h28, 4'd0, 1'b1};
        tbl[1] = '{1, 8'h00, 4'd2, 1'b0};
        tbl[2] = '{2, 8'hD7, 4'd8, 1'b0};
        tbl[3] = '{3, 8'hFF, 4'd6, 1'b0};
        tbl[4] = '{4, 8'hF0, 4'd4, 1'b0};

        #12;
        chk("reset_outputs", {a, b, c, busy, done, pass, fail_cnt, capture}, 17'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", busy, 1'b0);

`ifndef SWEEP_CONTINUOUS_EN
        for (int i = 0; i < 5; i++) run_sweep(tbl[i], 1'b0);
        run_sweep(tbl[0], 1'b1);

        // start together with abort in IDLE is ignored
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_with_abort_busy", busy, 1'b0);

        // abort in SETTLE of vector 3, with a stray start while busy
        mode = 2;
        pulse_start();
        bad = 0;
        seen0 = done_seen;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 7) start = 1'b1;
            if (j == 8) start = 1'b0;
            if ({a, b, c} !== exp_abc(j)) bad++;
        end
        chk("abc_seq_with_stray_start", bad, 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_abc", {a, b, c}, 3'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pass", pass, 1'b0);
        chk("abort_capture", capture, 8'h07);
        chk("abort_fail_cnt", fail_cnt, 4'd3);
        repeat (50) @(negedge clk);
        chk("abort_no_done", done_seen, seen0);
`else
        begin
            sb_t e;
            mode = 0;
            pulse_start();
            for (int k = 1; k <= 3; k++) begin
                e.cap = 8'h28; e.fc = 4'd0; e.ps = 1'b1; e.bsy = 1'b1; e.due = start_cyc + 41 * k;
                sb.push_back(e);
            end
            bad = 0;
            for (int w = 0; w < 200 && sb.size() != 0; w++) begin
                @(negedge clk);
                if (busy !== 1'b1) bad++;
            end
            chk("cont_done_timeout", sb.size(), 0);
            chk("cont_busy_held", bad, 0);
            seen0 = done_seen;
            abort = 1'b1;
            @(negedge clk); abort = 1'b0;
            chk("cont_abort_busy", busy, 1'b0);
            repeat (60) @(negedge clk);
            chk("cont_abort_no_done", done_seen, seen0);
        end
`endif

        // async reset mid-sweep, between clock edges
        mode = 2;
        pulse_start();
        repeat (12) @(negedge clk);
        chk("pre_reset_capture", capture, 8'h03);
        chk("pre_reset_fail_cnt", fail_cnt, 4'd2);
        seen0 = done_seen;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {a, b, c, busy, done, pass, fail_cnt, capture}, 17'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", {busy, a, b, c}, 4'd0);
        chk("post_reset_no_done", done_seen, seen0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_and_sweep_ctrl.md
Name: xor_and_sweep_ctrl

Overview:
- On-board self-test sequencer for the 3-input XOR-then-AND gate on Basys 3.
- On a start request it steps the gate inputs {a,b,c} through all 8 combinations and waits a programmable settle time for each one.
- It then samples the gate output y and checks it against a parameterised golden truth table.
- It reports the captured truth table, a mismatch count and pass/done status, for display on LEDs.

Parameters:
- EXP_TT, 8'h28: golden truth table. Bit i is the expected y when {a,b,c}=i. The default encodes y=(a^b)&c.
- SETTLE_CYC, 4: clock cycles each vector is held before sampling. Legal range 1..65535.
- CNT_W, 16: width of the settle counter. Must satisfy SETTLE_CYC <= 2^CNT_W-1.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request to begin a sweep. Ignored while busy=1.
- abort, input, 1: cancels a sweep that is in progress.
- y_in, input, 1: gate output under test. Synchronous to clk.
- a, input-drive output, 1: gate input a, equal to abc[2].
- b, output, 1: gate input b, equal to abc[1].
- c, output, 1: gate input c, equal to abc[0].
- busy, output, 1: high from the cycle after start is accepted until DONE or abort.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: high when the last completed sweep had zero mismatches. Held until the next start.
- fail_cnt, output, 4: number of mismatches in the current or last sweep (0..8).
- capture, output, 8: observed truth table. Bit i is the y sampled for vector i.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - abc=3'b000, busy=0, done=0, pass=0, fail_cnt=0, capture=8'h00.
  - Settle counter = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 leads to SETTLE, with abc=0, cnt=SETTLE_CYC-1, busy=1, fail_cnt=0, pass=0.
  - capture is cleared to 8'h00 on start.
- SETTLE:
  - If cnt==0, go to SAMPLE; otherwise decrement cnt.
  - The vector is therefore held for exactly SETTLE_CYC cycles before sampling.
- SAMPLE, one cycle:
  - capture[abc] <= y_in.
  - If y_in != EXP_TT[abc], increment fail_cnt.
  - If abc==7, go to DONE. Otherwise abc <= abc+1, cnt <= SETTLE_CYC-1, and go to SETTLE.
- DONE, one cycle:
  - done=1, busy=0.
  - pass = (fail_cnt==0), using the count after the final SAMPLE update.
  - Next state is IDLE; abc stays at 7 until the next start.
- Latency: done is high in the cycle 8*(SETTLE_CYC+1)+1 cycles after the edge that accepted start.
- abort=1 in SETTLE or SAMPLE:
  - Next state is IDLE; abc=0, busy=0, pass=0.
  - No done pulse. capture and fail_cnt keep their partial values.
  - A SAMPLE update in that same cycle is discarded.
- Simultaneous events:
  - abort has priority over every transition.
  - start with abort in IDLE: start is ignored.
  - start in the DONE cycle is ignored; start must be re-issued in IDLE.
- fail_cnt cannot exceed 8, so no saturation is needed.
- Reset asserted mid-sweep forces the reset values immediately, regardless of state.

Optional Feature:
- Macro: SWEEP_CONTINUOUS_EN.
- When defined:
  - DONE goes to SETTLE instead of IDLE.
  - The sweep restarts at abc=0, clearing fail_cnt and capture.
  - done still pulses and pass updates on every sweep.
  - busy stays at 1 from the first start until abort.
  - abort is the only exit.
- When not defined: single-shot sweeps as described in Behaviour.

Test Plan:
- Correct gate, default parameters:
  - Bench model y=(a^b)&c; pulse start.
  - Required: abc steps 0..7, each vector held 5 cycles.
  - done pulses once, 41 cycles after start; capture=8'h28, fail_cnt=0, pass=1, busy=0.
- Stuck-at-0 output:
  - y_in=0 constantly; start.
  - Required: capture=8'h00, fail_cnt=2, pass=0, done pulses once.
- Inverted gate:
  - y_in = ~((a^b)&c); start.
  - Required: capture=8'hD7, fail_cnt=8, pass=0.
- Abort mid-sweep:
  - Assert abort while in SETTLE with abc=3.
  - Required: next cycle state=IDLE, abc=0, busy=0, no done pulse, pass=0.
  - A start pulse during busy before the abort must not alter the abc sequence.
- Asynchronous reset:
  - Drop rst_n between clock edges during the sweep.
  - Required: all outputs zero without waiting for a clock edge.
  - After release, the block stays idle until start.
- SWEEP_CONTINUOUS_EN build:
  - Start once with the correct model.
  - Required: done pulses every 41 cycles, pass=1 each time, busy stays high.
  - abort returns busy=0 within 1 cycle.
